weight_ram_controller: RTL

- Sequences and arbitrates the single port of the three-layer weight block RAM (hidden 1, hidden 2, output layer) between two requesters.
- Requester 1, the forward-pass read-burst engine: streams every weight of one layer, in address order, to the neuron datapath.
- Requester 2, the single-word write requester: used for initial weight load and training updates.
- Drives the RAM's enable, read/write select, layer, address and data inputs. Read data returns directly from the RAM's own valid/layer/addr/weight outputs.

---
 rtl/weight_ram_controller.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/weight_ram_controller.sv
// Single-port weight RAM sequencer: forward-pass read bursts
// arbitrated against single-word weight writes.
module weight_ram_controller #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int ADDR_WIDTH                    = 11,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_rd_start,
  input  logic [LAYER_WIDTH-1:0] i_rd_layer,
  input  logic                   i_rd_ready,
  output logic                   o_rd_busy,
  output logic                   o_rd_done,
  output logic                   o_rd_err,
  input  logic                   i_wr_valid,
  input  logic [LAYER_WIDTH-1:0] i_wr_layer,
  input  logic [ADDR_WIDTH-1:0]  i_wr_addr,
  input  logic [DATA_WIDTH-1:0]  i_wr_data,
  output logic                   o_wr_ready,
  output logic                   o_wr_err,
  output logic                   o_ram_enable,
  output logic                   o_ram_rw_select,
  output logic [LAYER_WIDTH-1:0] o_ram_layer,
  output logic [ADDR_WIDTH-1:0]  o_ram_addr,
  output logic [DATA_WIDTH-1:0]  o_ram_data
);

  localparam int IN = NUMBER_OF_INPUT_NODE;
  localparam int H1 = NUMBER_OF_HIDDEN_NODE_LAYER_1;
  localparam int H2 = NUMBER_OF_HIDDEN_NODE_LAYER_2;
  localparam int OT = NUMBER_OF_OUTPUT_NODE;

  localparam int SW = ADDR_WIDTH + 1;

  localparam logic [SW-1:0] S1 = SW'(H1 * (IN + 1));
  localparam logic [SW-1:0] S2 = SW'(H2 * (H1 + 1));
  localparam logic [SW-1:0] S3 = SW'(OT * (H2 + 1));

  localparam logic [LAYER_WIDTH-1:0] L1 = LAYER_WIDTH'(1);
  localparam logic [LAYER_WIDTH-1:0] L2 = LAYER_WIDTH'(2);
  localparam logic [LAYER_WIDTH-1:0] L3 = LAYER_WIDTH'(3);
  localparam logic [LAYER_WIDTH-1:0] L0 = '0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_LAST  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [LAYER_WIDTH-1:0] rd_layer_q, rd_layer_d;
  logic                   last_grant_q, last_grant_d;
  logic                   rd_done_q, rd_done_d;
  logic                   rd_err_q, rd_err_d;
  logic                   wr_err_q, wr_err_d;

  logic            rd_req, wr_req;
  logic            gnt_rd, gnt_wr;
  logic            rd_last, wr_bad;
  logic [SW-1:0]   rd_size, wr_size;

  // Words per layer; zero marks the invalid layer code
  function automatic logic [SW-1:0] layer_size(
    input logic [LAYER_WIDTH-1:0] l
  );
    logic [SW-1:0] s;
    s = '0;
    unique case (1'b1)
      (l == L1): s = S1;
      (l == L2): s = S2;
      (l == L3): s = S3;
      default:   s = '0;
    endcase
    return s;
  endfunction

  assign rd_size = layer_size(rd_layer_q);
  assign wr_size = layer_size(i_wr_layer);
  assign rd_last = ({1'b0, rd_cnt_q} == rd_size - SW'(1));
  assign wr_bad  = (wr_size == '0) ||
                   ({1'b0, i_wr_addr} >= wr_size);

  // Per-cycle arbitration; write wins ties unless it won the last one
  always_comb begin
    rd_req = (state_q == ST_BURST) && i_rd_ready && !rst;
    wr_req = i_wr_valid && !rst;
    gnt_wr = wr_req && (!rd_req || !last_grant_q);
    gnt_rd = rd_req && !gnt_wr;
  end

  // RAM port drive from the winning requester
  always_comb begin
    o_wr_ready      = gnt_wr;
    o_ram_enable    = gnt_rd || (gnt_wr && !wr_bad);
    o_ram_rw_select = !gnt_wr;
    o_ram_layer     = gnt_wr ? i_wr_layer : rd_layer_q;
    o_ram_addr      = gnt_wr ? i_wr_addr : rd_cnt_q;
    o_ram_data      = i_wr_data;
  end

  // Burst sequencing and pulse generation
  always_comb begin
    state_d      = state_q;
    rd_cnt_d     = rd_cnt_q;
    rd_layer_d   = rd_layer_q;
    last_grant_d = last_grant_q;
    rd_done_d    = 1'b0;
    rd_err_d     = 1'b0;
    wr_err_d     = gnt_wr && wr_bad;
    if (rd_req && wr_req)
      last_grant_d = gnt_wr;
    unique case (state_q)
      ST_IDLE: begin
        if (i_rd_start) begin
          if (i_rd_layer == L0) begin
            rd_err_d = 1'b1;
          end else begin
            rd_layer_d = i_rd_layer;
            rd_cnt_d   = '0;
            state_d    = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (gnt_rd) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_last) begin
            state_d   = ST_LAST;
            rd_done_d = 1'b1;
          end
        end
      end
      ST_LAST: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rd_cnt_q     <= '0;
      rd_layer_q   <= '0;
      last_grant_q <= 1'b0;
      rd_done_q    <= 1'b0;
      rd_err_q     <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_layer_q   <= rd_layer_d;
      last_grant_q <= last_grant_d;
      rd_done_q    <= rd_done_d;
      rd_err_q     <= rd_err_d;
      wr_err_q     <= wr_err_d;
    end
  end

  assign o_rd_busy = (state_q != ST_IDLE);
  assign o_rd_done = rd_done_q;
  assign o_rd_err  = rd_err_q;
  assign o_wr_err  = wr_err_q;

endmodule
